// File: rtl/gpr_transfer_controller_if.sv
// -----------------------------------------------------------------------------
// gpr_transfer_controller_if
//
// Command / response channel between a client and gpr_transfer_controller.
//
// Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready
// are both 1. The client holds cmd_op/src/dst/imm stable while cmd_valid is
// high. cmd_valid may be dropped before acceptance with no effect. cmd_ready
// is high only while the controller is idle. The response is a one-cycle
// rsp_valid pulse with rsp_err/rsp_data qualified by it. There is no response
// backpressure.
//
// Signals:
//   cmd_valid  client -> ctrl  command present
//   cmd_ready  ctrl -> client  controller accepts a command this cycle
//   cmd_op     client -> ctrl  00 MOV, 01 LDI, 10 RD, 11 SWAP
//   cmd_src    client -> ctrl  source register select
//   cmd_dst    client -> ctrl  destination register select
//   cmd_imm    client -> ctrl  immediate for LDI
//   rsp_valid  ctrl -> client  one-cycle completion pulse
//   rsp_data   ctrl -> client  RD: register value, SWAP: original src value
//   rsp_err    ctrl -> client  1 = command rejected
//   busy       ctrl -> client  controller is not idle
//
// Modports: master = client side, slave = controller side.
// -----------------------------------------------------------------------------
interface gpr_transfer_controller_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [2:0] cmd_src;
  logic [2:0] cmd_dst;
  logic [7:0] cmd_imm;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_err;
  logic       busy;

  modport master (
    output cmd_valid, cmd_op, cmd_src, cmd_dst, cmd_imm,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err, busy
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_src, cmd_dst, cmd_imm,
    output cmd_ready, rsp_valid, rsp_data, rsp_err, busy
  );
endinterface

// File: rtl/gpr_transfer_controller.sv
// -----------------------------------------------------------------------------
// gpr_transfer_controller
//
// Sequencer for the 8x8 general purpose register file (A..H) and its shared
// bidirectional 8-bit data bus. One command at a time: MOV, LDI, RD, SWAP.
// The controller is the only bus master of the register file and never drives
// data_bus in a cycle where the file is asked to drive it.
//
// Optional feature macro: GPR_XFER_SWAP_EN
//   defined   : SWAP moves src->temp, dst->src, temp->dst (states SW1..SW3)
//   undefined : SWAP is accepted and answered with rsp_err=1, rsp_data=00
//
// Parameter:
//   RSP_ON_WRITE  1 = MOV/LDI also pulse rsp_valid, 0 = only RD/SWAP/errors
//
// Ports:
//   clock              system clock, rising edge
//   reset              synchronous, active-low
//   cmd_if             command/response channel (slave modport)
//   gpr_read_data      register file latches data_bus into gpr_input_select
//   gpr_write_data     register file drives gpr_output_select onto data_bus
//   gpr_input_select   write target in the register file
//   gpr_output_select  read source in the register file
//   data_bus           shared bus, driven only in LDI-XFER and SW3, else Z
//   state_dbg          current FSM state, for observation
// -----------------------------------------------------------------------------
module gpr_transfer_controller #(
  parameter bit RSP_ON_WRITE = 1'b1
) (
  input  logic                       clock,
  input  logic                       reset,
  gpr_transfer_controller_if.slave   cmd_if,
  output logic                       gpr_read_data,
  output logic                       gpr_write_data,
  output logic [2:0]                 gpr_input_select,
  output logic [2:0]                 gpr_output_select,
  inout  wire  [7:0]                 data_bus,
  output logic [2:0]                 state_dbg
);

  localparam logic [1:0] OP_MOV  = 2'b00;
  localparam logic [1:0] OP_LDI  = 2'b01;
  localparam logic [1:0] OP_RD   = 2'b10;
  localparam logic [1:0] OP_SWAP = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_XFER = 3'd1,
`ifdef GPR_XFER_SWAP_EN
    S_SW1  = 3'd2,
    S_SW2  = 3'd3,
    S_SW3  = 3'd4,
`endif
    S_RESP = 3'd5
  } state_e;

  state_e     state_q,    state_d;
  logic [1:0] op_q,       op_d;
`ifdef GPR_XFER_SWAP_EN
  logic [2:0] src_q,      src_d;
  logic [2:0] dst_q,      dst_d;
  logic [7:0] temp_q,     temp_d;
`endif
  // rsp_hold_q keeps the last RD/SWAP result; rsp_zero_q masks it to 00 on
  // responses that carry no data (MOV/LDI/error) without disturbing the hold.
  logic [7:0] rsp_hold_q, rsp_hold_d;
  logic       rsp_zero_q, rsp_zero_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic       rsp_err_q,  rsp_err_d;
  logic       busy_q,     busy_d;
  logic       rd_q,       rd_d;
  logic       wr_q,       wr_d;
  logic [2:0] in_sel_q,   in_sel_d;
  logic [2:0] out_sel_q,  out_sel_d;
  logic       drv_en_q,   drv_en_d;
  logic [7:0] drv_val_q,  drv_val_d;

  logic       accept;

  // Ready is gated by reset directly so it is low for the whole reset window.
  assign cmd_if.cmd_ready = (state_q == S_IDLE) && reset;
  assign accept           = cmd_if.cmd_valid && cmd_if.cmd_ready;

  // Next-state and next-output logic. Strobes/selects are computed for the
  // state being entered so that the registered outputs line up with it.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
`ifdef GPR_XFER_SWAP_EN
    src_d       = src_q;
    dst_d       = dst_q;
    temp_d      = temp_q;
`endif
    rsp_hold_d  = rsp_hold_q;
    rsp_zero_d  = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rd_d        = 1'b0;
    wr_d        = 1'b0;
    in_sel_d    = 3'b000;
    out_sel_d   = 3'b000;
    drv_en_d    = 1'b0;
    drv_val_d   = 8'h00;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d = cmd_if.cmd_op;
`ifdef GPR_XFER_SWAP_EN
          src_d = cmd_if.cmd_src;
          dst_d = cmd_if.cmd_dst;
`endif
          case (cmd_if.cmd_op)
            OP_MOV: begin
              state_d   = S_XFER;
              wr_d      = 1'b1;
              out_sel_d = cmd_if.cmd_src;
              rd_d      = 1'b1;
              in_sel_d  = cmd_if.cmd_dst;
            end
            OP_LDI: begin
              // The immediate is captured straight into the drive register.
              state_d   = S_XFER;
              drv_en_d  = 1'b1;
              drv_val_d = cmd_if.cmd_imm;
              rd_d      = 1'b1;
              in_sel_d  = cmd_if.cmd_dst;
            end
            OP_RD: begin
              state_d   = S_XFER;
              wr_d      = 1'b1;
              out_sel_d = cmd_if.cmd_src;
            end
            OP_SWAP: begin
`ifdef GPR_XFER_SWAP_EN
              state_d   = S_SW1;
              wr_d      = 1'b1;
              out_sel_d = cmd_if.cmd_src;
`else
              // Swap not built: reject immediately with no register access.
              state_d     = S_RESP;
              rsp_valid_d = 1'b1;
              rsp_err_d   = 1'b1;
              rsp_zero_d  = 1'b1;
`endif
            end
            default: state_d = S_IDLE;
          endcase
        end
      end

      S_XFER: begin
        state_d = S_RESP;
        if (op_q == OP_RD) begin
          rsp_hold_d  = data_bus;
          rsp_valid_d = 1'b1;
        end else begin
          rsp_valid_d = RSP_ON_WRITE;
          rsp_zero_d  = 1'b1;
        end
      end

`ifdef GPR_XFER_SWAP_EN
      S_SW1: begin
        // src is on the bus now; keep it as temp and as the response value.
        temp_d     = data_bus;
        rsp_hold_d = data_bus;
        state_d    = S_SW2;
        wr_d       = 1'b1;
        out_sel_d  = dst_q;
        rd_d       = 1'b1;
        in_sel_d   = src_q;
      end

      S_SW2: begin
        state_d   = S_SW3;
        drv_en_d  = 1'b1;
        drv_val_d = temp_q;
        rd_d      = 1'b1;
        in_sel_d  = dst_q;
      end

      S_SW3: begin
        state_d     = S_RESP;
        rsp_valid_d = 1'b1;
      end
`endif

      S_RESP: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      op_q        <= OP_MOV;
`ifdef GPR_XFER_SWAP_EN
      src_q       <= 3'b000;
      dst_q       <= 3'b000;
      temp_q      <= 8'h00;
`endif
      rsp_hold_q  <= 8'h00;
      rsp_zero_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      in_sel_q    <= 3'b000;
      out_sel_q   <= 3'b000;
      drv_en_q    <= 1'b0;
      drv_val_q   <= 8'h00;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
`ifdef GPR_XFER_SWAP_EN
      src_q       <= src_d;
      dst_q       <= dst_d;
      temp_q      <= temp_d;
`endif
      rsp_hold_q  <= rsp_hold_d;
      rsp_zero_q  <= rsp_zero_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      busy_q      <= busy_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      in_sel_q    <= in_sel_d;
      out_sel_q   <= out_sel_d;
      drv_en_q    <= drv_en_d;
      drv_val_q   <= drv_val_d;
    end
  end

  // drv_en_q and wr_q are never set together by the next-state logic, so the
  // controller and the register file never drive the bus in the same cycle.
  assign data_bus = drv_en_q ? drv_val_q : 8'hzz;

  assign cmd_if.rsp_valid = rsp_valid_q;
  assign cmd_if.rsp_err   = rsp_err_q;
  assign cmd_if.rsp_data  = rsp_zero_q ? 8'h00 : rsp_hold_q;
  assign cmd_if.busy      = busy_q;

  assign gpr_read_data     = rd_q;
  assign gpr_write_data    = wr_q;
  assign gpr_input_select  = in_sel_q;
  assign gpr_output_select = out_sel_q;
  assign state_dbg         = state_q;

endmodule

// File: tb/tb_gpr_transfer_controller.sv
// -----------------------------------------------------------------------------
// tb_gpr_transfer_controller
//
// Drives gpr_transfer_controller against a behavioural register-file model on
// data_bus, and checks responses against a command-level reference model.
// Builds with or without GPR_XFER_SWAP_EN.
// -----------------------------------------------------------------------------
module tb_gpr_transfer_controller;

  localparam bit RSP_ON_WRITE = 1'b1;
  localparam int W = 41;  // {expected cycle[31:0], err, data[7:0]}
  localparam int BUDGET = 20;

  localparam logic [1:0] MOV  = 2'b00;
  localparam logic [1:0] LDI  = 2'b01;
  localparam logic [1:0] RD   = 2'b10;
  localparam logic [1:0] SWAP = 2'b11;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  gpr_transfer_controller_if cif ();
  logic       gpr_read_data, gpr_write_data;
  logic [2:0] gpr_input_select, gpr_output_select;
  logic [2:0] state_dbg;
  wire  [7:0] data_bus;

  gpr_transfer_controller #(.RSP_ON_WRITE(RSP_ON_WRITE)) dut (
    .clock             (clock),
    .reset             (reset),
    .cmd_if            (cif),
    .gpr_read_data     (gpr_read_data),
    .gpr_write_data    (gpr_write_data),
    .gpr_input_select  (gpr_input_select),
    .gpr_output_select (gpr_output_select),
    .data_bus          (data_bus),
    .state_dbg         (state_dbg)
  );

  // ---------------- register file environment ----------------
  logic [7:0] rf [8];
  assign data_bus = gpr_write_data ? rf[gpr_output_select] : 8'hzz;
  always @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < 8; i++) rf[i] <= 8'h00;
    end else if (gpr_read_data) begin
      rf[gpr_input_select] <= data_bus;
    end
  end

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;
  logic mon_en = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model + scoreboard ----------------
  logic [7:0] mregs [8];
  logic [W-1:0] exp_q [$];

  task automatic accept_model(input logic [1:0] op, input logic [2:0] src,
                              input logic [2:0] dst, input logic [7:0] imm);
    logic [7:0] t;
    logic       has;
    logic [8:0] pay;
    int         lat;
    has = 1'b1;
    lat = 2;
    pay = 9'h000;
    t   = 8'h00;
    case (op)
      MOV: begin mregs[dst] = mregs[src]; has = RSP_ON_WRITE; end
      LDI: begin mregs[dst] = imm;        has = RSP_ON_WRITE; end
      RD:  pay = {1'b0, mregs[src]};
      default: begin
`ifdef GPR_XFER_SWAP_EN
        t = mregs[src];
        mregs[src] = mregs[dst];
        mregs[dst] = t;
        pay = {1'b0, t};
        lat = 4;
`else
        pay = {1'b1, 8'h00};
        lat = 1;
`endif
      end
    endcase
    if (has) exp_q.push_back({32'(cyc + lat), pay});
  endtask

  always @(negedge clock) begin
    logic [W-1:0] e;
    if (mon_en && cif.rsp_valid === 1'b1) begin
      check("rsp_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("rsp_cycle", 64'(cyc), 64'(e[40:9]));
        check("rsp_err_data", {55'd0, cif.rsp_err, cif.rsp_data}, {55'd0, e[8:0]});
      end
    end
  end

  // Per-cycle bus and handshake invariants.
  always @(negedge clock) begin
    if (mon_en) begin
      check("bus_contention", 64'(dut.drv_en_q & gpr_write_data), 64'd0);
      if (dut.drv_en_q === 1'b1 || gpr_write_data === 1'b1)
        check("bus_known", 64'(^data_bus === 1'bx), 64'd0);
      check("cmd_ready_idle", 64'(cif.cmd_ready), 64'(reset & ~cif.busy));
      if (cif.busy !== 1'b1)
        check("idle_quiet", {56'd0, gpr_read_data, gpr_write_data, gpr_input_select,
                             gpr_output_select}, 64'd0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_ready();
    int waited = 0;
    while (cif.cmd_ready !== 1'b1 && waited < BUDGET) begin
      @(negedge clock);
      waited++;
    end
    check("ready_timeout", 64'(waited < BUDGET), 64'd1);
  endtask

  task automatic wait_idle();
    int waited = 0;
    @(negedge clock);
    while (cif.cmd_ready !== 1'b1 && waited < BUDGET) begin
      @(negedge clock);
      waited++;
    end
    check("idle_timeout", 64'(waited < BUDGET), 64'd1);
    check("rsp_missing", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic do_cmd(input logic [1:0] op, input logic [2:0] src,
                        input logic [2:0] dst, input logic [7:0] imm);
    @(negedge clock);
    cif.cmd_valid = 1'b1;
    cif.cmd_op    = op;
    cif.cmd_src   = src;
    cif.cmd_dst   = dst;
    cif.cmd_imm   = imm;
    wait_ready();
    accept_model(op, src, dst, imm);
    @(negedge clock);
    cif.cmd_valid = 1'b0;
    wait_idle();
  endtask

  // ---------------- stimulus ----------------
  int acc [3];

  initial begin
    cif.cmd_valid = 1'b0;
    cif.cmd_op    = MOV;
    cif.cmd_src   = 3'd0;
    cif.cmd_dst   = 3'd0;
    cif.cmd_imm   = 8'h00;
    for (int i = 0; i < 8; i++) mregs[i] = 8'h00;

    // Reset state.
    repeat (3) @(negedge clock);
    check("rst_cmd_ready", 64'(cif.cmd_ready), 64'd0);
    check("rst_rsp_valid", 64'(cif.rsp_valid), 64'd0);
    check("rst_rsp_err",   64'(cif.rsp_err),   64'd0);
    check("rst_busy",      64'(cif.busy),      64'd0);
    check("rst_rsp_data",  64'(cif.rsp_data),  64'd0);
    check("rst_strobes",   {56'd0, gpr_read_data, gpr_write_data, gpr_input_select,
                            gpr_output_select}, 64'd0);
    check("rst_bus_released", 64'(dut.drv_en_q), 64'd0);
    reset = 1'b1;
    mon_en = 1'b1;
    @(negedge clock);
    check("idle_ready", 64'(cif.cmd_ready), 64'd1);

    // LDI C=5A then read back.
    do_cmd(LDI, 3'd0, 3'd2, 8'h5A);
    do_cmd(RD,  3'd2, 3'd0, 8'h00);

    // LDI A, MOV A->H, read both.
    do_cmd(LDI, 3'd0, 3'd0, 8'h11);
    do_cmd(MOV, 3'd0, 3'd7, 8'h00);
    do_cmd(RD,  3'd7, 3'd0, 8'h00);
    do_cmd(RD,  3'd0, 3'd0, 8'h00);

    // Swap A/B, then read both.
    do_cmd(LDI,  3'd0, 3'd0, 8'h3C);
    do_cmd(LDI,  3'd0, 3'd1, 8'hC3);
    do_cmd(SWAP, 3'd0, 3'd1, 8'h00);
    do_cmd(RD,   3'd0, 3'd0, 8'h00);
    do_cmd(RD,   3'd1, 3'd0, 8'h00);

    // src==dst boundaries.
    do_cmd(SWAP, 3'd2, 3'd2, 8'h00);
    do_cmd(RD,   3'd2, 3'd0, 8'h00);
    do_cmd(MOV,  3'd7, 3'd7, 8'h00);
    do_cmd(RD,   3'd7, 3'd0, 8'h00);

    // Command presented only while busy, then dropped: must have no effect.
    @(negedge clock);
    cif.cmd_valid = 1'b1;
    cif.cmd_op    = LDI;
    cif.cmd_dst   = 3'd4;
    cif.cmd_imm   = 8'h77;
    wait_ready();
    accept_model(LDI, 3'd0, 3'd4, 8'h77);
    @(negedge clock);
    cif.cmd_dst   = 3'd5;
    cif.cmd_imm   = 8'hFF;
    @(negedge clock);
    cif.cmd_valid = 1'b0;
    wait_idle();
    do_cmd(RD, 3'd5, 3'd0, 8'h00);
    do_cmd(RD, 3'd4, 3'd0, 8'h00);

    // Back-to-back LDIs to D with cmd_valid held high.
    @(negedge clock);
    cif.cmd_valid = 1'b1;
    cif.cmd_op    = LDI;
    cif.cmd_src   = 3'd0;
    cif.cmd_dst   = 3'd3;
    cif.cmd_imm   = 8'h01;
    for (int k = 0; k < 3; k++) begin
      wait_ready();
      acc[k] = cyc;
      accept_model(LDI, 3'd0, 3'd3, 8'(k + 1));
      @(negedge clock);
      if (k < 2) cif.cmd_imm = 8'(k + 2);
      else       cif.cmd_valid = 1'b0;
    end
    wait_idle();
    check("b2b_gap0", 64'(acc[1] - acc[0]), 64'd3);
    check("b2b_gap1", 64'(acc[2] - acc[1]), 64'd3);
    do_cmd(RD, 3'd3, 3'd0, 8'h00);

    // Randomized commands.
    for (int n = 0; n < 40; n++) begin
      do_cmd(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
             3'($urandom_range(0, 7)), 8'($urandom));
    end

    // Reset in the middle of a command: no response, registers cleared.
    @(negedge clock);
    cif.cmd_valid = 1'b1;
`ifdef GPR_XFER_SWAP_EN
    cif.cmd_op    = SWAP;
`else
    cif.cmd_op    = LDI;
`endif
    cif.cmd_src   = 3'd0;
    cif.cmd_dst   = 3'd1;
    cif.cmd_imm   = 8'h99;
    wait_ready();
    @(negedge clock);
    cif.cmd_valid = 1'b0;
`ifdef GPR_XFER_SWAP_EN
    @(negedge clock);
`endif
    reset = 1'b0;
    @(negedge clock);
    check("midrst_strobes", {56'd0, gpr_read_data, gpr_write_data, gpr_input_select,
                             gpr_output_select}, 64'd0);
    check("midrst_cmd_ready", 64'(cif.cmd_ready), 64'd0);
    check("midrst_rsp_valid", 64'(cif.rsp_valid), 64'd0);
    check("midrst_busy",      64'(cif.busy),      64'd0);
    repeat (2) begin
      @(negedge clock);
      check("midrst_no_rsp", 64'(cif.rsp_valid), 64'd0);
    end
    for (int i = 0; i < 8; i++) mregs[i] = 8'h00;
    reset = 1'b1;
    do_cmd(RD, 3'd0, 3'd0, 8'h00);
    do_cmd(RD, 3'd1, 3'd0, 8'h00);
    do_cmd(RD, 3'd2, 3'd0, 8'h00);

    repeat (2) @(negedge clock);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
